apb_gpio: RTL and testbench
===========================

Name:
apb_gpio

Overview:
- 8-bit GPIO output controller with an APB slave interface; sits between the APB bus and eight physical output pins (pin1..pin8).
- Software programs an output-enable (direction) mask and an output data latch through the registers below.
- Output data is changed via atomic SET/CLR write registers or by direct write.
- A status register reads back the effective pin levels.
- Zero-wait-state slave; no PREADY/PSLVERR.

Parameters:
- None. Data width 8 and address width 3 are fixed.

Ports:
- PCLK  input  1  APB clock; all state updates on rising edge.
- PRESETn  input  1  asynchronous, active-low reset.
- PADDR  input  3  register address.
- PWDATA  input  8  write data.
- PWRITE  input  1  1 = write, 0 = read.
- PSEL  input  1  slave select.
- PENABLE  input  1  APB access phase.
- PRDATA  output  8  read data.
- pin1..pin8  output  1 each  GPIO pins; pinN corresponds to bit N-1 (pin1 = bit0, pin8 = bit7).

Behaviour:
- Reset: PRESETn low clears DIR and OUT immediately, independent of PCLK. While reset is held, all pins = 0 and PRDATA = 0x00.
- Write strobe: wr = PSEL & PENABLE & PWRITE, sampled at the rising edge of PCLK.
  - The register updates at that edge, so the new pin value is visible right after the access-phase edge.
  - If PENABLE stays high for several cycles, the write is re-applied each cycle. This is harmless because SET and CLR are idempotent.
  - No write occurs in the setup phase (PSEL=1, PENABLE=0) or when PSEL=0.
- Register map:
  - 0x0 DIR, R/W. Bit=1 enables that pin as a driven output.
  - 0x1 SET, W. OUT <= OUT | PWDATA. Reads return OUT.
  - 0x2 CLR, W. OUT <= OUT & ~PWDATA. Reads return OUT.
  - 0x3 OUT, R/W. Direct load of the output latch.
  - 0x4 STATUS, RO. Returns OUT & DIR; writes are ignored.
  - 0x5-0x7 reserved. Writes are ignored; reads return 0x00.
- Zero bits: a SET or CLR write with PWDATA=0x00 leaves OUT unchanged.
- DIR writes: OUT retains its value across DIR changes.
- Pins: pin[i] = DIR[i] & OUT[i], combinational from the registers. A disabled pin drives 0, never X or Z.
- Read data:
  - PRDATA = mux(PADDR) while PSEL=1 and PWRITE=0, in both setup and access phases. It is combinational, with zero wait states.
  - Otherwise PRDATA = 0x00.
- Reset mid-transfer: the transfer is aborted and nothing is written. After PRESETn deasserts, the next valid access phase behaves normally.

Test Plan:
- Reset: hold PRESETn=0, then write DIR=0xFF and SET=0xFF with full APB handshakes -> pins stay 0 and PRDATA stays 0x00. Release reset -> DIR=0x00, OUT=0x00.
- Write DIR=0x08, then SET=0x08 -> pin4=1, all other pins 0. Then CLR=0x00 -> pin4 remains 1 and STATUS=0x08.
- Write DIR=0x09, then SET=0x01 -> pin1=1, pin4=1 (STATUS=0x09). Then CLR=0x08 -> pin4=0, pin1=1, STATUS=0x01.
- Write DIR=0x08 with OUT=0x01 -> all pins 0. Read 0x4 -> PRDATA=0x00. Read 0x1 -> PRDATA=0x01.
- Protocol: setup phase only (PSEL=1, PENABLE=0, PWRITE=1, PADDR=1, PWDATA=0xFF), then PSEL=0 -> OUT unchanged. Write 0x3=0xA5 with DIR=0xFF -> pins = 0xA5 (pin1=1, pin8=1).
- Reserved addresses: write 0x7=0xFF -> no register change. Read 0x5 -> PRDATA=0x00. With PSEL=0 -> PRDATA=0x00.

Source files
------------

// File: rtl/apb_gpio.sv
// 8-bit APB GPIO output controller: direction mask, output latch with atomic SET/CLR,
// and a status readback of the effective pin levels. Zero-wait-state slave.
module apb_gpio (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic [2:0] PADDR,
  input  logic [7:0] PWDATA,
  input  logic       PWRITE,
  input  logic       PSEL,
  input  logic       PENABLE,
  output logic [7:0] PRDATA,
  output logic       pin1,
  output logic       pin2,
  output logic       pin3,
  output logic       pin4,
  output logic       pin5,
  output logic       pin6,
  output logic       pin7,
  output logic       pin8
);

  localparam logic [2:0] AddrDir    = 3'h0;
  localparam logic [2:0] AddrSet    = 3'h1;
  localparam logic [2:0] AddrClr    = 3'h2;
  localparam logic [2:0] AddrOut    = 3'h3;
  localparam logic [2:0] AddrStatus = 3'h4;

  logic [7:0] dir_q, dir_d;
  logic [7:0] out_q, out_d;
  logic [7:0] pins;
  logic       wr;
  logic       rd;

  assign wr = PSEL & PENABLE & PWRITE;
  // Reads are served in both setup and access phases.
  assign rd = PSEL & ~PWRITE;

  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    if (wr) begin
      case (PADDR)
        AddrDir: dir_d = PWDATA;
        AddrSet: out_d = out_q | PWDATA;
        AddrClr: out_d = out_q & ~PWDATA;
        AddrOut: out_d = PWDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      dir_q <= 8'h00;
      out_q <= 8'h00;
    end else begin
      dir_q <= dir_d;
      out_q <= out_d;
    end
  end

  assign pins = dir_q & out_q;

  always_comb begin
    PRDATA = 8'h00;
    if (rd) begin
      case (PADDR)
        AddrDir:                 PRDATA = dir_q;
        AddrSet, AddrClr, AddrOut: PRDATA = out_q;
        AddrStatus:              PRDATA = pins;
        default:                 PRDATA = 8'h00;
      endcase
    end
  end

  assign pin1 = pins[0];
  assign pin2 = pins[1];
  assign pin3 = pins[2];
  assign pin4 = pins[3];
  assign pin5 = pins[4];
  assign pin6 = pins[5];
  assign pin7 = pins[6];
  assign pin8 = pins[7];

endmodule

// File: tb/tb_apb_gpio.sv
// Directed bench for apb_gpio: a register-level model checked every cycle plus
// literal expectations taken from the register map.
module tb_apb_gpio;

  logic       PCLK;
  logic       PRESETn;
  logic [2:0] PADDR;
  logic [7:0] PWDATA;
  logic       PWRITE;
  logic       PSEL;
  logic       PENABLE;
  logic [7:0] PRDATA;
  logic       pin1, pin2, pin3, pin4, pin5, pin6, pin7, pin8;
  logic [7:0] pins;

  int tests = 0;
  int fails = 0;
  bit check_en = 0;

  // Model state: what software has programmed.
  logic [7:0] m_dir;
  logic [7:0] m_out;

  apb_gpio dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PRDATA  (PRDATA),
    .pin1    (pin1),
    .pin2    (pin2),
    .pin3    (pin3),
    .pin4    (pin4),
    .pin5    (pin5),
    .pin6    (pin6),
    .pin7    (pin7),
    .pin8    (pin8)
  );

  assign pins = {pin8, pin7, pin6, pin5, pin4, pin3, pin2, pin1};

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] a);
    if (a == 3'd0) return m_dir;
    if (a >= 3'd1 && a <= 3'd3) return m_out;
    if (a == 3'd4) return m_dir & m_out;
    return 8'h00;
  endfunction

  always @(negedge PCLK) begin
    if (check_en) begin
      chk("pins", pins, m_dir & m_out);
      chk("prdata", PRDATA, (PSEL && !PWRITE) ? model_read(PADDR) : 8'h00);
    end
  end

  task automatic apply_model_write(input logic [2:0] a, input logic [7:0] d);
    if (PRESETn) begin
      case (a)
        3'd0: m_dir = d;
        3'd1: m_out = m_out | d;
        3'd2: m_out = m_out & ~d;
        3'd3: m_out = d;
        default: ;
      endcase
    end
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [7:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK);
    apply_model_write(a, d);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] a, input logic [7:0] exp, input string name);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    chk(name, PRDATA, exp);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic assert_reset();
    PRESETn = 1'b0;
    m_dir = 8'h00;
    m_out = 8'h00;
  endtask

  initial begin
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    m_dir = 8'h00; m_out = 8'h00;
    PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    check_en = 1;

    // Writes during reset must not land.
    apb_write(3'd0, 8'hFF);
    apb_write(3'd1, 8'hFF);
    chk("rst_pins", pins, 8'h00);
    apb_read(3'd0, 8'h00, "rst_rd_dir");
    PRESETn = 1'b1;
    apb_read(3'd0, 8'h00, "post_rst_dir");
    apb_read(3'd3, 8'h00, "post_rst_out");

    apb_write(3'd0, 8'h08);
    apb_write(3'd1, 8'h08);
    chk("pin4_only", pins, 8'h08);
    apb_write(3'd2, 8'h00);
    chk("clr_zero", pins, 8'h08);
    apb_read(3'd4, 8'h08, "status_08");

    apb_write(3'd0, 8'h09);
    apb_write(3'd1, 8'h01);
    apb_read(3'd4, 8'h09, "status_09");
    apb_write(3'd2, 8'h08);
    chk("pin4_clr", pins, 8'h01);
    apb_read(3'd4, 8'h01, "status_01");

    apb_write(3'd0, 8'h08);
    chk("dir_masks", pins, 8'h00);
    apb_read(3'd4, 8'h00, "status_masked");
    apb_read(3'd1, 8'h01, "rd_set_out");
    apb_read(3'd2, 8'h01, "rd_clr_out");

    // Setup phase only, never an access phase.
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 3'd1; PWDATA = 8'hFF;
    @(posedge PCLK); #1;
    PSEL = 0; PWRITE = 0;
    @(posedge PCLK); #1;
    apb_read(3'd3, 8'h01, "setup_only");

    apb_write(3'd0, 8'hFF);
    apb_write(3'd3, 8'hA5);
    chk("pins_a5", pins, 8'hA5);
    chk("pin1", {7'd0, pin1}, 8'h01);
    chk("pin8", {7'd0, pin8}, 8'h01);

    // Held access phase re-applies SET harmlessly.
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 3'd1; PWDATA = 8'h02;
    @(posedge PCLK); #1;
    PENABLE = 1;
    repeat (3) begin
      @(posedge PCLK);
      apply_model_write(3'd1, 8'h02);
    end
    #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
    chk("held_set", pins, 8'hA7);

    apb_write(3'd7, 8'hFF);
    apb_read(3'd0, 8'hFF, "rsvd_dir");
    apb_read(3'd3, 8'hA7, "rsvd_out");
    apb_read(3'd5, 8'h00, "rd_rsvd5");
    apb_read(3'd7, 8'h00, "rd_rsvd7");
    apb_write(3'd4, 8'h00);
    apb_read(3'd4, 8'hA7, "status_ro");
    PADDR = 3'd0; PWRITE = 0; PSEL = 0;
    #2;
    chk("psel0_rd", PRDATA, 8'h00);

    // Reset in the middle of an access phase aborts the write.
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 3'd3; PWDATA = 8'h3C;
    @(posedge PCLK); #1;
    PENABLE = 1;
    #2;
    assert_reset();
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
    PRESETn = 1'b1;
    apb_read(3'd3, 8'h00, "abort_out");
    apb_read(3'd0, 8'h00, "abort_dir");
    apb_write(3'd0, 8'h81);
    apb_write(3'd3, 8'hFF);
    chk("post_abort", pins, 8'h81);

    repeat (2) @(posedge PCLK);
    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
